// File: rtl/tile_xy_ring_router_if.sv
// Link, inject and eject signals of one tile_xy_ring_router stage.
// The router connects through the slave modport; its environment uses master.
interface tile_xy_ring_router_if #(
  parameter int unsigned FW = 68
);
  logic          lo_in_vld;
  logic [FW-1:0] lo_in_flit;
  logic          hi_in_vld;
  logic [FW-1:0] hi_in_flit;
  logic          lo_crd_out;
  logic          hi_crd_out;
  logic          lo_out_vld;
  logic [FW-1:0] lo_out_flit;
  logic          hi_out_vld;
  logic [FW-1:0] hi_out_flit;
  logic          lo_crd_in;
  logic          hi_crd_in;
  logic          inj_vld;
  logic [FW-1:0] inj_flit;
  logic          inj_rdy;
  logic          ej_vld;
  logic [FW-1:0] ej_flit;
  logic          ej_rdy;
  logic [2:0]    af;
  logic          err_ovf;
  logic          err_crd;

  modport master (
    output lo_in_vld, lo_in_flit, hi_in_vld, hi_in_flit,
    output lo_crd_in, hi_crd_in, inj_vld, inj_flit, ej_rdy,
    input  lo_crd_out, hi_crd_out, lo_out_vld, lo_out_flit, hi_out_vld, hi_out_flit,
    input  inj_rdy, ej_vld, ej_flit, af, err_ovf, err_crd
  );

  modport slave (
    input  lo_in_vld, lo_in_flit, hi_in_vld, hi_in_flit,
    input  lo_crd_in, hi_crd_in, inj_vld, inj_flit, ej_rdy,
    output lo_crd_out, hi_crd_out, lo_out_vld, lo_out_flit, hi_out_vld, hi_out_flit,
    output inj_rdy, ej_vld, ej_flit, af, err_ovf, err_crd
  );
endinterface

// File: rtl/tile_xy_ring_router.sv
// One-dimension ring router stage: lo/hi/inj input FIFOs, per-destination
// round-robin arbitration, credit-based link flow control, held eject register.
module tile_xy_ring_router #(
  parameter int unsigned TILE_X  = 0,
  parameter int unsigned TILE_Y  = 0,
  parameter int unsigned DIM     = 0,
  parameter int unsigned COORD_W = 2,
  parameter int unsigned DW      = 64,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AF_LVL  = 6,
  localparam int unsigned FW     = 2*COORD_W + DW,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input logic                  clk,
  input logic                  rst_n,
  tile_xy_ring_router_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NS = 3;
  localparam logic [COORD_W-1:0] OWN = (DIM == 0) ? COORD_W'(TILE_X) : COORD_W'(TILE_Y);

  typedef enum logic [1:0] {DST_HI = 2'd0, DST_LO = 2'd1, DST_EJ = 2'd2} dst_e;

  // Sources: 0 = lo FIFO, 1 = hi FIFO, 2 = inj FIFO
  logic [FW-1:0]      mem     [NS][DEPTH];
  logic [AW-1:0]      wp      [NS];
  logic [AW-1:0]      rp      [NS];
  logic [CW-1:0]      occ     [NS];
  logic [CW-1:0]      occ_nxt [NS];
  logic [FW-1:0]      in_flit [NS];
  logic [FW-1:0]      head    [NS];
  logic [COORD_W-1:0] coord   [NS];
  dst_e               dst     [NS];
  logic [NS-1:0]      in_vld, full, empty, wr, pop;

  // Destinations indexed by dst_e
  logic [1:0]    rr    [NS];
  logic [1:0]    gnt_s [NS];
  logic [NS-1:0] can, gnt_v;
  logic [1:0]    cand;

  logic [CW-1:0] crd [2];
  logic [1:0]    send, crd_in;
  logic          ovf;

  logic          lo_out_vld_q, hi_out_vld_q, ej_vld_q;
  logic [FW-1:0] lo_out_flit_q, hi_out_flit_q, ej_flit_q;
  logic          lo_crd_q, hi_crd_q, err_ovf_q, err_crd_q;
  logic [2:0]    af_q;

  function automatic logic [1:0] wrap3(input int unsigned v);
    return 2'(v % NS);
  endfunction

  always_comb begin
    in_vld     = {bus.inj_vld, bus.hi_in_vld, bus.lo_in_vld};
    in_flit[0] = bus.lo_in_flit;
    in_flit[1] = bus.hi_in_flit;
    in_flit[2] = bus.inj_flit;
    crd_in     = {bus.hi_crd_in, bus.lo_crd_in};
  end

  always_comb begin
    for (int unsigned s = 0; s < NS; s++) begin
      full[s]  = (occ[s] == CW'(DEPTH));
      empty[s] = (occ[s] == '0);
      head[s]  = mem[s][rp[s]];
      coord[s] = (DIM == 0) ? head[s][DW +: COORD_W] : head[s][DW+COORD_W +: COORD_W];
      if (coord[s] > OWN)      dst[s] = DST_HI;
      else if (coord[s] < OWN) dst[s] = DST_LO;
      else                     dst[s] = DST_EJ;
    end
  end

  // A head has exactly one destination, so per-destination grants never
  // collide on a source and a single pop vector suffices.
  always_comb begin
    can[DST_HI] = (crd[1] != '0);
    can[DST_LO] = (crd[0] != '0);
    can[DST_EJ] = !ej_vld_q || bus.ej_rdy;
    gnt_v = '0;
    pop   = '0;
    cand  = '0;
    for (int unsigned d = 0; d < NS; d++) gnt_s[d] = '0;
    for (int unsigned d = 0; d < NS; d++) begin
      for (int unsigned k = 0; k < NS; k++) begin
        cand = wrap3(32'(rr[d]) + k);
        if (can[d] && !gnt_v[d] && !empty[cand] && dst[cand] == dst_e'(2'(d))) begin
          gnt_v[d] = 1'b1;
          gnt_s[d] = cand;
        end
      end
      if (gnt_v[d]) pop[gnt_s[d]] = 1'b1;
    end
  end

  always_comb begin
    wr[0] = in_vld[0] && (!full[0] || pop[0]);
    wr[1] = in_vld[1] && (!full[1] || pop[1]);
    wr[2] = in_vld[2] && !full[2];
    ovf   = (in_vld[0] && full[0] && !pop[0]) || (in_vld[1] && full[1] && !pop[1]);
    for (int unsigned s = 0; s < NS; s++)
      occ_nxt[s] = occ[s] + CW'(wr[s]) - CW'(pop[s]);
    send = {gnt_v[DST_HI], gnt_v[DST_LO]};
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < NS; s++)
      if (wr[s]) mem[s][wp[s]] <= in_flit[s];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NS; s++) begin
        wp[s]  <= '0;
        rp[s]  <= '0;
        occ[s] <= '0;
        rr[s]  <= '0;
      end
      crd[0]        <= CW'(DEPTH);
      crd[1]        <= CW'(DEPTH);
      lo_out_vld_q  <= 1'b0;
      hi_out_vld_q  <= 1'b0;
      ej_vld_q      <= 1'b0;
      lo_out_flit_q <= '0;
      hi_out_flit_q <= '0;
      ej_flit_q     <= '0;
      lo_crd_q      <= 1'b0;
      hi_crd_q      <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_crd_q     <= 1'b0;
      af_q          <= '0;
    end else begin
      for (int unsigned s = 0; s < NS; s++) begin
        if (wr[s])  wp[s] <= wp[s] + 1'b1;
        if (pop[s]) rp[s] <= rp[s] + 1'b1;
        occ[s]  <= occ_nxt[s];
        af_q[s] <= (occ_nxt[s] >= CW'(AF_LVL));
        if (gnt_v[s]) rr[s] <= (gnt_s[s] == 2'd2) ? 2'd0 : gnt_s[s] + 2'd1;
      end
      for (int unsigned l = 0; l < 2; l++) begin
        if (send[l] && !crd_in[l]) begin
          crd[l] <= crd[l] - 1'b1;
        end else if (crd_in[l] && !send[l]) begin
          if (crd[l] == CW'(DEPTH)) err_crd_q <= 1'b1;
          else                      crd[l]    <= crd[l] + 1'b1;
        end
      end
      hi_out_vld_q <= gnt_v[DST_HI];
      if (gnt_v[DST_HI]) hi_out_flit_q <= head[gnt_s[DST_HI]];
      lo_out_vld_q <= gnt_v[DST_LO];
      if (gnt_v[DST_LO]) lo_out_flit_q <= head[gnt_s[DST_LO]];
      if (gnt_v[DST_EJ]) begin
        ej_vld_q  <= 1'b1;
        ej_flit_q <= head[gnt_s[DST_EJ]];
      end else if (bus.ej_rdy) begin
        ej_vld_q  <= 1'b0;
      end
      lo_crd_q <= pop[0];
      hi_crd_q <= pop[1];
      if (ovf) err_ovf_q <= 1'b1;
    end
  end

  assign bus.lo_out_vld  = lo_out_vld_q;
  assign bus.lo_out_flit = lo_out_flit_q;
  assign bus.hi_out_vld  = hi_out_vld_q;
  assign bus.hi_out_flit = hi_out_flit_q;
  assign bus.ej_vld      = ej_vld_q;
  assign bus.ej_flit     = ej_flit_q;
  assign bus.lo_crd_out  = lo_crd_q;
  assign bus.hi_crd_out  = hi_crd_q;
  assign bus.inj_rdy     = !full[2];
  assign bus.af          = af_q;
  assign bus.err_ovf     = err_ovf_q;
  assign bus.err_crd     = err_crd_q;
endmodule

// File: tb/tb_tile_xy_ring_router.sv
// Bench for tile_xy_ring_router (TILE_X=1, DIM=0): routing vector table,
// directed corner sequences, and random traffic against a per-flow queue model.
module tb_tile_xy_ring_router;
  localparam int unsigned COORD_W = 2;
  localparam int unsigned DW      = 16;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned AF_LVL  = 6;
  localparam int unsigned FW      = 2*COORD_W + DW;
  localparam int MY_X = 1;
  localparam int HI = 0, LO = 1, EJ = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  tile_xy_ring_router_if #(.FW(FW)) bus ();

  tile_xy_ring_router #(
    .TILE_X(MY_X), .TILE_Y(2), .DIM(0), .COORD_W(COORD_W),
    .DW(DW), .DEPTH(DEPTH), .AF_LVL(AF_LVL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  typedef struct {
    int             src;
    logic [1:0]     dx;
    logic [1:0]     dy;
    logic [DW-1:0]  pl;
    int             port;
  } vec_t;
  vec_t vecs [9];

  logic [FW-1:0] q [9][$];  // expected flits per (source, destination)

  function automatic logic [FW-1:0] mk(input logic [1:0] dx, input logic [1:0] dy, input logic [DW-1:0] pl);
    return {dy, dx, pl};
  endfunction

  function automatic int route(input logic [FW-1:0] f);
    int dx;
    dx = int'(f[DW +: 2]);
    if (dx > MY_X) return HI;
    if (dx < MY_X) return LO;
    return EJ;
  endfunction

  function automatic logic [10:0] status();
    return {bus.lo_out_vld, bus.hi_out_vld, bus.ej_vld, bus.lo_crd_out, bus.hi_crd_out,
            bus.af, bus.err_ovf, bus.err_crd, bus.inj_rdy};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic take(input int port, input logic [FW-1:0] f, input string name);
    int idx;
    logic [FW-1:0] e;
    idx = int'(f[DW-1 -: 2]) * 3 + port;
    checks++;
    if (idx > 8 || q[idx].size() == 0) begin
      errors++;
      $display("FAIL %s: got unexpected flit %0h expected none at %0t", name, f, $time);
    end else begin
      e = q[idx].pop_front();
      if (f !== e) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, f, e, $time);
      end
    end
  endtask

  task automatic idle();
    bus.lo_in_vld = 1'b0; bus.lo_in_flit = '0;
    bus.hi_in_vld = 1'b0; bus.hi_in_flit = '0;
    bus.inj_vld   = 1'b0; bus.inj_flit   = '0;
    bus.lo_crd_in = 1'b0; bus.hi_crd_in  = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    idle();
    bus.ej_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input int src, input logic [FW-1:0] f);
    case (src)
      0:       begin bus.lo_in_vld = 1'b1; bus.lo_in_flit = f; end
      1:       begin bus.hi_in_vld = 1'b1; bus.hi_in_flit = f; end
      default: begin bus.inj_vld   = 1'b1; bus.inj_flit   = f; end
    endcase
  endtask

  initial begin
    logic [FW-1:0] f, act;
    int sent, n, cnt, total, seq;
    int order [6];
    int up_cr [2];
    int dn_cr [2];
    int owed  [2];
    int pend  [2];
    bit drain;

    vecs[0] = '{0, 2'd3, 2'd0, 16'h1234, HI};
    vecs[1] = '{0, 2'd0, 2'd1, 16'h0001, LO};
    vecs[2] = '{0, 2'd1, 2'd3, 16'hbeef, EJ};
    vecs[3] = '{1, 2'd2, 2'd2, 16'h5555, HI};
    vecs[4] = '{1, 2'd0, 2'd0, 16'haaaa, LO};
    vecs[5] = '{1, 2'd1, 2'd1, 16'h0f0f, EJ};
    vecs[6] = '{2, 2'd3, 2'd3, 16'hffff, HI};
    vecs[7] = '{2, 2'd0, 2'd2, 16'h8001, LO};
    vecs[8] = '{2, 2'd1, 2'd2, 16'h7e7e, EJ};

    do_reset();
    chk("reset_status", 64'(status()), 64'h001);
    chk("reset_flits", {bus.lo_out_flit, bus.hi_out_flit, bus.ej_flit}, '0);

    // Routing table: 2-cycle latency, right port, identical flit, credit pulse
    bus.ej_rdy = 1'b1;
    foreach (vecs[i]) begin
      f = mk(vecs[i].dx, vecs[i].dy, vecs[i].pl);
      send(vecs[i].src, f);
      cyc();
      chk("vec_lat1", {bus.hi_out_vld, bus.lo_out_vld, bus.ej_vld}, 3'b000);
      cyc();
      chk("vec_port", {bus.hi_out_vld, bus.lo_out_vld, bus.ej_vld}, 3'b100 >> vecs[i].port);
      case (vecs[i].port)
        HI:      begin act = bus.hi_out_flit; bus.hi_crd_in = 1'b1; end
        LO:      begin act = bus.lo_out_flit; bus.lo_crd_in = 1'b1; end
        default: act = bus.ej_flit;
      endcase
      chk("vec_flit", act, f);
      chk("vec_crd_out", {bus.hi_crd_out, bus.lo_crd_out},
          (vecs[i].src == 0) ? 2'b01 : (vecs[i].src == 1) ? 2'b10 : 2'b00);
      cyc();
    end

    // Eject hold with ej_rdy low for 5 cycles
    bus.ej_rdy = 1'b0;
    f = mk(2'd1, 2'd2, 16'hc0de);
    send(2, f);
    cyc();
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("ej_hold_vld", {bus.ej_vld, bus.hi_out_vld, bus.lo_out_vld}, 3'b100);
      chk("ej_hold_flit", bus.ej_flit, f);
      if (k < 4) cyc();
    end
    bus.ej_rdy = 1'b1;
    cyc();
    chk("ej_drained", bus.ej_vld, 1'b0);

    // Round robin on eject
    do_reset();
    bus.ej_rdy = 1'b1;
    n = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 2) begin
        send(0, mk(2'd1, 2'd0, {2'd0, 14'(c)}));
        send(1, mk(2'd1, 2'd0, {2'd1, 14'(c)}));
        send(2, mk(2'd1, 2'd0, {2'd2, 14'(c)}));
      end
      cyc();
      if (bus.ej_vld && n < 6) begin
        order[n] = int'(bus.ej_flit[DW-1 -: 2]);
        n++;
      end
    end
    chk("rr_count", n, 6);
    for (int i = 0; i < 6; i++) chk("rr_order", order[i], i % 3);

    // Credit return at DEPTH, then credit starvation on the hi link
    do_reset();
    bus.hi_crd_in = 1'b1;
    cyc();
    chk("err_crd", {bus.err_crd, bus.err_ovf}, 2'b10);
    sent = 0;
    for (int k = 0; k < 9; k++) begin
      send(0, mk(2'd3, 2'd0, 16'(k)));
      cyc();
      if (bus.hi_out_vld) sent++;
    end
    repeat (10) begin
      cyc();
      if (bus.hi_out_vld) sent++;
    end
    chk("starve_sent", sent, DEPTH);
    bus.hi_crd_in = 1'b1;
    cyc();
    chk("starve_wait", bus.hi_out_vld, 1'b0);
    cyc();
    chk("starve_9th_vld", bus.hi_out_vld, 1'b1);
    chk("starve_9th_flit", bus.hi_out_flit, mk(2'd3, 2'd0, 16'd8));

    // Overflow: eject blocked, lo FIFO fills, 10th flit dropped
    do_reset();
    bus.ej_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      send(0, mk(2'd1, 2'd0, 16'(k)));
      cyc();
      if (k == 5) chk("af_below", bus.af, 3'b000);
      if (k == 6) chk("af_at_lvl", bus.af, 3'b001);
      if (k == 8) chk("ovf_before", bus.err_ovf, 1'b0);
      if (k == 9) chk("ovf_set", {bus.err_ovf, bus.err_crd}, 2'b10);
    end
    bus.ej_rdy = 1'b1;
    cnt = 0;
    act = '0;
    repeat (30) begin
      if (bus.ej_vld) begin
        cnt++;
        act = bus.ej_flit;
      end
      cyc();
    end
    chk("ovf_kept", cnt, 9);
    chk("ovf_last", act, mk(2'd1, 2'd0, 16'd8));

    // Asynchronous reset with flits queued
    do_reset();
    bus.ej_rdy = 1'b0;
    for (int k = 0; k < 7; k++) begin
      send(0, mk(2'd1, 2'd0, 16'(k)));
      cyc();
    end
    cyc();
    chk("prereset", {bus.ej_vld, bus.af}, 4'b1001);
    #2 rst_n = 1'b0;
    #1;
    chk("async_status", 64'(status()), 64'h001);
    chk("async_flits", {bus.lo_out_flit, bus.hi_out_flit, bus.ej_flit}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ej_rdy = 1'b1;
    cnt = 0;
    repeat (6) begin
      cyc();
      if (bus.ej_vld) cnt++;
    end
    chk("async_empty", cnt, 0);
    chk("async_inj_rdy", bus.inj_rdy, 1'b1);

    // Random traffic against per-flow ordering and credit model
    do_reset();
    for (int l = 0; l < 2; l++) begin
      up_cr[l] = DEPTH; dn_cr[l] = DEPTH; owed[l] = 0; pend[l] = 0;
    end
    seq = 0;
    for (int c = 0; c < 1800; c++) begin
      drain = (c >= 1500);
      if (bus.lo_out_vld) begin
        chk("lo_crd_avail", 64'(dn_cr[0] > 0), 1);
        dn_cr[0]--; owed[0]++;
        take(LO, bus.lo_out_flit, "lo_out");
      end
      if (bus.hi_out_vld) begin
        chk("hi_crd_avail", 64'(dn_cr[1] > 0), 1);
        dn_cr[1]--; owed[1]++;
        take(HI, bus.hi_out_flit, "hi_out");
      end
      for (int l = 0; l < 2; l++) begin
        dn_cr[l] += pend[l];
        pend[l] = 0;
      end
      if (bus.lo_crd_out) up_cr[0]++;
      if (bus.hi_crd_out) up_cr[1]++;
      bus.ej_rdy = drain || ($urandom_range(0, 3) != 0);
      if (bus.ej_vld && bus.ej_rdy) take(EJ, bus.ej_flit, "ej_out");
      if (owed[0] > 0 && (drain || $urandom_range(0, 1) == 1)) begin
        bus.lo_crd_in = 1'b1; owed[0]--; pend[0] = 1;
      end
      if (owed[1] > 0 && (drain || $urandom_range(0, 1) == 1)) begin
        bus.hi_crd_in = 1'b1; owed[1]--; pend[1] = 1;
      end
      if (!drain) begin
        for (int s = 0; s < 3; s++) begin
          if ($urandom_range(0, 1) == 1 && (s == 2 ? bus.inj_rdy : up_cr[s] > 0)) begin
            f = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'(s), 14'(seq)};
            seq++;
            if (s < 2) up_cr[s]--;
            send(s, f);
            q[s*3 + route(f)].push_back(f);
          end
        end
      end
      cyc();
    end
    total = 0;
    for (int i = 0; i < 9; i++) total += q[i].size();
    chk("rand_drained", total, 0);
    chk("rand_up_lo", up_cr[0], DEPTH);
    chk("rand_up_hi", up_cr[1], DEPTH);
    chk("rand_err", {bus.err_ovf, bus.err_crd}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
